// File: rtl/cnn1d_pkg.sv
// Shared types and helpers for the cnn1d input path: framer FSM states and ADC-to-Q conversion.
package cnn1d_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2,
        DRAIN  = 2'd3
    } framer_state_t;

    localparam int Q_MAX_W = 64;

    // Sign-extend an adc_width-bit sample and align its MSB-1 with the binary point,
    // so full-scale ADC maps onto [-1, 1) in a Q(fraction) word.
    function automatic logic [Q_MAX_W-1:0] q_from_adc(
        input logic [Q_MAX_W-1:0] adc,
        input int                 adc_width,
        input int                 fraction
    );
        logic signed [Q_MAX_W-1:0] sx;
        sx = adc << (Q_MAX_W - adc_width);
        sx = sx >>> (Q_MAX_W - adc_width);
        return sx << (fraction - adc_width + 1);
    endfunction

endpackage

// File: rtl/cnn1d_fifo.sv
// First-word-fall-through FIFO with a registered output word; write-to-valid latency 2 edges.
// Backpressure: rd_ready stalls the output word; writes while full are ignored (caller sees full).
module cnn1d_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    mem_cnt;
    logic             push;
    logic             pop;
    logic             load;

    // count covers the output register too, so DEPTH is the total capacity
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en & ~full;
    assign pop     = rd_valid & rd_ready;
    assign mem_cnt = count - CW'(rd_valid);
    assign load    = (mem_cnt != '0) & (~rd_valid | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr   <= rd_ptr + AW'(1);
                rd_data  <= mem[rd_ptr];
                rd_valid <= 1'b1;
            end else if (pop) begin
                rd_valid <= 1'b0;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/cnn1d_sample_framer.sv
// Converts an unstallable ADC stream to Q-format and emits whole FRAME_LEN frames to cnn1d.
// Latency: write at edge N, valid after N+1. Backpressure: framer_ready_out stalls output; full FIFO drops samples and sets overflow.
module cnn1d_sample_framer
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRACTION   = 24,
    parameter int ADC_WIDTH  = 16,
    parameter int FRAME_LEN  = 128,
    parameter int FIFO_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adc_valid_in,
    input  logic [ADC_WIDTH-1:0]  adc_data_in,
    input  logic                  framer_enable,
    input  logic                  overflow_clr,
    output logic                  framer_valid_out,
    output logic [DATA_WIDTH-1:0] framer_data_out,
    output logic                  framer_last_out,
    input  logic                  framer_ready_out,
    output logic                  overflow_out,
    output logic                  busy_out
);

    localparam int                CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    framer_state_t         state;
    framer_state_t         state_nxt;
    logic [CNT_W-1:0]      wr_cnt;
    logic [CNT_W-1:0]      rd_cnt;
    logic [DATA_WIDTH-1:0] sample_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  wr_try;
    logic                  wr_ok;
    logic                  wr_wrap;
    logic                  rd_ok;
    logic                  busy;

    assign sample_q = DATA_WIDTH'(q_from_adc(Q_MAX_W'(adc_data_in), ADC_WIDTH, FRACTION));
    assign wr_ok    = wr_try & ~fifo_full;
    assign wr_wrap  = wr_ok & (wr_cnt == LAST_IDX);
    assign rd_ok    = framer_valid_out & framer_ready_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (framer_enable) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!framer_enable) begin
                    state_nxt = ((wr_cnt == '0) || wr_wrap) ? DRAIN : FINISH;
                end
            end
            FINISH: begin
                if (wr_wrap) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A disable seen on a frame boundary must not let that cycle's sample start a new frame
    always_comb begin
        wr_try = 1'b0;
        busy   = 1'b1;
        case (state)
            IDLE:    busy   = 1'b0;
            RUN:     wr_try = adc_valid_in & (framer_enable | (wr_cnt != '0));
            FINISH:  wr_try = adc_valid_in;
            default: wr_try = 1'b0;
        endcase
    end

    assign busy_out = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            overflow_out <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_cnt <= wr_wrap ? '0 : wr_cnt + CNT_W'(1);
            end
            if (rd_ok) begin
                rd_cnt <= (rd_cnt == LAST_IDX) ? '0 : rd_cnt + CNT_W'(1);
            end
            if (wr_try & fifo_full) begin
                overflow_out <= 1'b1;
            end else if (overflow_clr) begin
                overflow_out <= 1'b0;
            end
        end
    end

    assign framer_last_out = (rd_cnt == LAST_IDX) & framer_valid_out;

    cnn1d_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_ok),
        .wr_data  (sample_q),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .rd_data  (framer_data_out),
        .rd_valid (framer_valid_out),
        .rd_ready (framer_ready_out)
    );

endmodule

// File: tb/tb_cnn1d_sample_framer.sv
// Directed bench for cnn1d_sample_framer with a scoreboard of hand-computed output words.
module tb_cnn1d_sample_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        adc_valid_in;
    logic [15:0] adc_data_in;
    logic        framer_enable;
    logic        overflow_clr;
    logic        framer_valid_out;
    logic [31:0] framer_data_out;
    logic        framer_last_out;
    logic        framer_ready_out;
    logic        overflow_out;
    logic        busy_out;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] expq[$];
    int          out_idx     = 0;
    int          out_total   = 0;
    bit          rand_rdy    = 1'b0;

    cnn1d_sample_framer dut (
        .clk              (clk),
        .rst              (rst),
        .adc_valid_in     (adc_valid_in),
        .adc_data_in      (adc_data_in),
        .framer_enable    (framer_enable),
        .overflow_clr     (overflow_clr),
        .framer_valid_out (framer_valid_out),
        .framer_data_out  (framer_data_out),
        .framer_last_out  (framer_last_out),
        .framer_ready_out (framer_ready_out),
        .overflow_out     (overflow_out),
        .busy_out         (busy_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: snapshot the output side, advance, then score handshakes and holds.
    task automatic tick();
        logic        v;
        logic        r;
        logic        l;
        logic [31:0] d;
        logic [31:0] e;
        if (rand_rdy) framer_ready_out = 1'($urandom_range(0, 1));
        v = framer_valid_out;
        r = framer_ready_out;
        d = framer_data_out;
        l = framer_last_out;
        @(posedge clk);
        #1;
        if (v && r) begin
            chk("sb_has_entry", 32'(expq.size() != 0), 1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("out_data", d, e);
                chk("out_last", 32'(l), 32'(out_idx == 127));
            end
            out_idx = (out_idx == 127) ? 0 : out_idx + 1;
            out_total++;
        end else if (v && !r) begin
            chk("hold_valid", 32'(framer_valid_out), 1);
            chk("hold_data", framer_data_out, d);
            chk("hold_last", 32'(framer_last_out), 32'(l));
        end
    endtask

    task automatic wr(input logic [15:0] s, input logic [31:0] e, input bit keep);
        adc_valid_in = 1'b1;
        adc_data_in  = s;
        if (keep) expq.push_back(e);
        tick();
        adc_valid_in = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (expq.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        chk(tag, 32'(expq.size()), 0);
    endtask

    initial begin
        rst              = 1'b1;
        adc_valid_in     = 1'b0;
        adc_data_in      = 16'h0000;
        framer_enable    = 1'b0;
        overflow_clr     = 1'b0;
        framer_ready_out = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(framer_valid_out), 0);
        chk("rst_data", framer_data_out, 0);
        chk("rst_last", 32'(framer_last_out), 0);
        chk("rst_ovf", 32'(overflow_out), 0);
        chk("rst_busy", 32'(busy_out), 0);
        rst = 1'b0;

        // Ramp, ready high; the sample in the enabling cycle must be ignored
        framer_enable = 1'b1;
        adc_valid_in  = 1'b1;
        adc_data_in   = 16'h1234;
        tick();
        adc_valid_in = 1'b0;
        chk("busy_run", 32'(busy_out), 1);
        for (int i = 0; i < 128; i++) begin
            wr(16'(i), 32'(i) * 32'h200, 1'b1);
            if (i == 0) chk("lat_not_yet", 32'(framer_valid_out), 0);
            if (i == 1) begin
                chk("lat_valid", 32'(framer_valid_out), 1);
                chk("lat_data", framer_data_out, 32'h0000_0000);
            end
        end
        drain("ramp_drain");
        chk("ramp_count", 32'(out_total), 128);
        tick();
        chk("ramp_empty", 32'(framer_valid_out), 0);

        // Conversion corners plus negative values, random ready
        rand_rdy = 1'b1;
        for (int k = 0; k < 128; k++) begin
            case (k)
                0:       wr(16'h4000, 32'h0080_0000, 1'b1);
                1:       wr(16'h8000, 32'hFF00_0000, 1'b1);
                2:       wr(16'h7FFF, 32'h00FF_FE00, 1'b1);
                default: wr(16'(-k), 32'(-k * 512), 1'b1);
            endcase
        end
        drain("rand_drain");
        rand_rdy         = 1'b0;
        framer_ready_out = 1'b1;
        chk("rand_count", 32'(out_total), 256);

        // Overflow: 257 writes with ready low, then clear/set priority
        framer_ready_out = 1'b0;
        for (int k = 0; k < 256; k++) wr(16'(k), 32'(k) * 32'h200, 1'b1);
        chk("ovf_before", 32'(overflow_out), 0);
        wr(16'h0BAD, 32'h0, 1'b0);
        chk("ovf_set", 32'(overflow_out), 1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("ovf_clr", 32'(overflow_out), 0);
        overflow_clr = 1'b1;
        wr(16'h0BAD, 32'h0, 1'b0);
        overflow_clr = 1'b0;
        chk("ovf_set_wins", 32'(overflow_out), 1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("ovf_clr2", 32'(overflow_out), 0);
        framer_ready_out = 1'b1;
        wr(16'h0BAD, 32'h0, 1'b0);
        chk("ovf_full_with_read", 32'(overflow_out), 1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("ovf_clr3", 32'(overflow_out), 0);
        drain("ovf_drain");
        chk("ovf_count", 32'(out_total), 512);

        // Disable after 40 samples: frame completes, FINISH -> DRAIN -> IDLE
        for (int k = 0; k < 40; k++) wr(16'(16'h0100 + k), 32'h0002_0000 + 32'(k) * 32'h200, 1'b1);
        framer_enable = 1'b0;
        for (int k = 40; k < 128; k++) begin
            wr(16'(16'h0100 + k), 32'h0002_0000 + 32'(k) * 32'h200, 1'b1);
            if (k == 60) chk("busy_finish", 32'(busy_out), 1);
        end
        for (int n = 0; n < 40 && busy_out; n++) wr(16'h0DEF, 32'h0, 1'b0);
        chk("busy_fall", 32'(busy_out), 0);
        chk("busy_fall_q", 32'(expq.size()), 0);
        chk("finish_count", 32'(out_total), 640);
        repeat (3) wr(16'h0DEF, 32'h0, 1'b0);
        chk("idle_ignore", 32'(framer_valid_out), 0);

        // Reset mid-frame with data buffered
        framer_enable = 1'b1;
        tick();
        rand_rdy = 1'b1;
        for (int k = 0; k < 150; k++) wr(16'(16'h0300 + k), 32'h0006_0000 + 32'(k) * 32'h200, 1'b1);
        rand_rdy         = 1'b0;
        framer_ready_out = 1'b1;
        rst              = 1'b1;
        #1;
        chk("arst_valid", 32'(framer_valid_out), 0);
        chk("arst_data", framer_data_out, 0);
        chk("arst_last", 32'(framer_last_out), 0);
        chk("arst_busy", 32'(busy_out), 0);
        chk("arst_ovf", 32'(overflow_out), 0);
        expq.delete();
        out_idx   = 0;
        out_total = 0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 128; k++) wr(16'(16'h2000 + k), 32'h0040_0000 + 32'(k) * 32'h200, 1'b1);
        drain("post_rst_drain");
        chk("post_rst_count", 32'(out_total), 128);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cnn1d_sample_framer.md
# cnn1d_sample_framer

Upstream input stage for `cnn1d`. Accepts a free-running stream of signed ADC samples that cannot be stalled, converts each to the network's Q-format fixed point, buffers in a FIFO and presents whole frames to `cnn1d` over a valid/ready handshake with a last-sample marker. Samples that arrive while the FIFO is full are dropped and flagged with a sticky overflow.

## Interface
- `DATA_WIDTH`, 32, output word width; must match `cnn1d`.
- `FRACTION`, 24, fractional bits of the output format; must match `cnn1d`.
- `ADC_WIDTH`, 16, signed ADC sample width; requires `FRACTION >= ADC_WIDTH-1` and `DATA_WIDTH > FRACTION`.
- `FRAME_LEN`, 128, samples per frame; must be at least 2.
- `FIFO_DEPTH`, 256, FIFO entries; must be a power of 2 and at least `FRAME_LEN`.
- `clk`, input, 1, sole clock.
- `rst`, input, 1, asynchronous, active-high reset.
- `adc_valid_in`, input, 1, sample strobe; there is no ready back to the ADC.
- `adc_data_in`, input, ADC_WIDTH, two's-complement sample.
- `framer_enable`, input, 1, level; starts and stops framing.
- `overflow_clr`, input, 1, single-cycle clear of `overflow_out`.
- `framer_valid_out`, output, 1, drives `cnn_valid_in` of `cnn1d`.
- `framer_data_out`, output, DATA_WIDTH, drives `cnn_data_in`.
- `framer_last_out`, output, 1, high on the last sample of each frame.
- `framer_ready_out`, input, 1, driven by `cnn_ready_in` of `cnn1d`.
- `overflow_out`, output, 1, sticky: at least one sample has been dropped.
- `busy_out`, output, 1, high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, RUN, FINISH, DRAIN. Reset state is IDLE.
- **IDLE**: `adc_valid_in` is ignored. Go to RUN when `framer_enable`=1.
- **RUN**: every `adc_valid_in` sample is converted and written to the FIFO. The input counter `wr_cnt` (0..FRAME_LEN-1) advances on each accepted write and wraps.
  - If `framer_enable`=0 and `wr_cnt`=0: go to DRAIN.
  - If `framer_enable`=0 and `wr_cnt`≠0: go to FINISH.
- **FINISH**: keep writing until the write that wraps `wr_cnt` to 0, then go to DRAIN. Only whole frames ever enter the FIFO.
- **DRAIN**: no writes. Go to IDLE once the FIFO is empty and no output word is pending. `framer_enable` is ignored until IDLE is reached.
- Conversion: `framer_data_out` = sign_extend(`adc_data_in`) << (FRACTION-ADC_WIDTH+1), so the full ADC range maps onto [-1,1). Examples with the defaults (shift 9):
  - 0x4000 → 0x00800000 (0.5)
  - 0x8000 → 0xFF000000 (-1.0)
  - 0x7FFF → 0x00FFFE00
- Overflow rule:
  - A write is attempted when the FIFO is full at the start of the cycle: the sample is dropped and `overflow_out` is set. This holds even if a read occurs in the same cycle.
  - `wr_cnt` does not advance on a dropped sample, so frames stay FRAME_LEN long.
  - `overflow_clr` clears `overflow_out`. If a set and a clear occur in the same cycle, set wins.
- Output side:
  - A frame counter `rd_cnt` advances on each handshake (`framer_valid_out` & `framer_ready_out`).
  - `framer_last_out` = (`rd_cnt` = FRAME_LEN-1) & `framer_valid_out`.
- `framer_enable` toggling in RUN or FINISH never truncates a frame.

## Timing
- All outputs reset to 0 asynchronously. Both counters, FIFO pointers and the FSM reset too. Reset mid-frame discards all buffered data, with no partial frame emitted afterwards.
- Latency: a sample written at edge N into an empty FIFO is presented with `framer_valid_out`=1 after edge N+1.
- Handshake:
  - Once `framer_valid_out` is high, `framer_data_out` and `framer_last_out` hold stable until the handshake occurs.
  - `framer_valid_out` never depends combinationally on `framer_ready_out`.
- Throughput: one word per cycle sustained while `framer_ready_out`=1.
- Simultaneous write and read on a non-full FIFO: both occur and the occupancy is unchanged.
- Pointer wrap-around at FIFO_DEPTH is seamless.
- Transition into RUN takes effect on the edge after `framer_enable` rises. `adc_valid_in` in that same cycle is ignored.

## Structure
- `cnn1d_pkg` holds:
  - the FSM state enum `framer_state_t` {IDLE, RUN, FINISH, DRAIN};
  - a `q_from_adc` conversion function, parameterised by widths.
- Sub-module `cnn1d_fifo`: synchronous FIFO with first-word-fall-through, a registered output, and `full`/`empty` flags from a count of width $clog2(FIFO_DEPTH)+1.
- The framer top holds the FSM, both counters, the conversion and the overflow flag.

## Test plan
- Enable, write ramp 0x0000..0x007F, ready held high → 128 outputs 0x00000000..0x0000FE00 in steps of 0x200. `framer_last_out` is high only on the 128th output; the first is valid one cycle after the first write.
- Random `framer_ready_out` with 50% duty → data and last stable while valid & !ready, no loss, and output order matches input order.
- Ready held low and 257 consecutive samples written → first 256 buffered, 257th dropped, `overflow_out`=1. The remainder of the frame is FRAME_LEN long after resume. `overflow_clr` clears the flag; a coincident set keeps it at 1.
- `framer_enable` dropped after 40 samples of a frame → writes continue to 128, the FSM passes through FINISH then DRAIN and reaches IDLE. Exactly one complete frame is output and `busy_out` falls after the last handshake.
- Values 0x4000, 0x8000 and 0x7FFF → outputs 0x00800000, 0xFF000000 and 0x00FFFE00.
- `rst` asserted mid-frame with the FIFO half full → all outputs 0 immediately. After re-enable, the next output frame starts at a new sample with `rd_cnt`=0.
